// File: rtl/mem_port_pkg.sv
// Shared datapath types for the memory port: access-size codes (funct3),
// the port FSM state encoding and a store-size legality helper.
package mem_port_pkg;

  // funct3 load/store size codes as driven by the datapath
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } mem_port_state_t;

  // Stores only know B/H/W; the unsigned codes are load-only.
  function automatic logic store_size_ok(input logic [2:0] size);
    logic ok;
    case (size)
      MEM_B, MEM_H, MEM_W: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a 32-bit bus: byte enables, store
// data replication, load extraction with sign/zero extension, and the
// misaligned/invalid-size flag (load view; store-only limits are added by
// the caller).
module mem_lane_align
  import mem_port_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the returned bus word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = bus_rdata[7:0];
      2'd1:    byte_s = bus_rdata[15:8];
      2'd2:    byte_s = bus_rdata[23:16];
      2'd3:    byte_s = bus_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = bus_rdata[31:16];
    end else begin
      half_s = bus_rdata[15:0];
    end
  end

  // Decode the size code into lane enables, replicated store data and extended load data.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    load_data = 32'h0000_0000;
    fault     = 1'b0;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{byte_s[7]}}, byte_s};
      end
      MEM_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {24'h00_0000, byte_s};
      end
      MEM_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{half_s[15]}}, half_s};
        fault     = addr_lo[0];
      end
      MEM_HU: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_data = {16'h0000, half_s};
        fault     = addr_lo[0];
      end
      MEM_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = bus_rdata;
        fault     = (addr_lo != 2'b00);
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Memory port between the multi-cycle control FSM and the external bus.
// A one-cycle mem_read/mem_write pulse starts an access; MAR/MDR/size are
// sampled the following cycle, then a req/gnt/rvalid transaction runs and a
// single-cycle mem_resp (with mem_err) reports completion.
// Optional: define MEM_PORT_TIMEOUT_EN to enable a bus watchdog that aborts
// the access with mem_err after TIMEOUT_CYCLES cycles in REQ/WAIT.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_resp,
  output logic              mem_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  mem_port_state_t state_r;
  mem_port_state_t state_next_s;

  logic        we_r;
  logic [2:0]  size_r;
  logic [1:0]  addr_lo_r;

  logic [2:0]  sel_size_s;
  logic [1:0]  sel_addr_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] load_data_s;
  logic        align_fault_s;
  logic        fault_s;
  logic        err_next_s;
  logic        load_en_s;
  logic        timeout_s;

  // In ACCEPT the live MAR/size are decoded; afterwards the sampled copy drives load extraction.
  assign sel_size_s = (state_r == ST_ACCEPT) ? mem_size  : size_r;
  assign sel_addr_s = (state_r == ST_ACCEPT) ? addr[1:0] : addr_lo_r;

  mem_lane_align u_align (
    .size      (sel_size_s),
    .addr_lo   (sel_addr_s),
    .wdata     (wdata),
    .bus_rdata (bus_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .load_data (load_data_s),
    .fault     (align_fault_s)
  );

  assign fault_s = align_fault_s | (we_r & ~store_size_ok(mem_size));

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_r;

  // Watchdog: cleared while in ACCEPT (the only way into REQ), counts through REQ and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_ACCEPT) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign timeout_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) && (tmo_cnt_r == CNT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, error and load-capture decisions.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = 1'b0;
    load_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_read & mem_write) begin
          state_next_s = ST_RESP;
          err_next_s   = 1'b1;
        end else if (mem_read | mem_write) begin
          state_next_s = ST_ACCEPT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (fault_s) begin
          state_next_s = ST_RESP;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timeout_s) begin
          state_next_s = ST_RESP;
          err_next_s   = 1'b1;
        end else if (bus_gnt & bus_rvalid) begin
          // zero-wait memory: grant and completion in the same cycle
          state_next_s = ST_RESP;
          load_en_s    = ~we_r;
        end else if (bus_gnt) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (timeout_s) begin
          state_next_s = ST_RESP;
          err_next_s   = 1'b1;
        end else if (bus_rvalid) begin
          state_next_s = ST_RESP;
          load_en_s    = ~we_r;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      we_r      <= 1'b0;
      size_r    <= 3'b000;
      addr_lo_r <= 2'b00;
      rdata     <= {DATA_W{1'b0}};
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= {ADDR_W{1'b0}};
      bus_be    <= 4'b0000;
      bus_wdata <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      mem_resp <= (state_next_s == ST_RESP);
      mem_err  <= (state_next_s == ST_RESP) & err_next_s;
      bus_req  <= (state_next_s == ST_REQ);
      if (state_r == ST_IDLE) begin
        we_r <= mem_write;
      end
      if (state_r == ST_ACCEPT) begin
        size_r    <= mem_size;
        addr_lo_r <= addr[1:0];
        bus_we    <= we_r;
        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus_be    <= be_s;
        bus_wdata <= wdata_rep_s;
      end
      if (load_en_s) begin
        rdata <= load_data_s;
      end else if ((state_r == ST_ACCEPT) && fault_s) begin
        rdata <= {DATA_W{1'b0}};
      end
    end
  end

endmodule
